wb_commit_stage: RTL

Parametrised write-back/commit stage for the 5-stage in-order core, replacing the fixed 32-bit write-back stage. It latches the MEM-stage payload through the valid/allowin handshake and aligns and extends load data in WB. It selects the ALU, load or CSR result, drives the register-file write, forwarding and trace ports, and commits precise exceptions and `ertn` with a pipeline flush. It also keeps a retired-instruction counter.

---
 rtl/core_pkg.sv | 35 +++
 rtl/load_extend.sv | 41 ++++
 rtl/wb_commit_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core encodings and MEM-to-WB bus geometry
package core_pkg;

    // load_op[1:0] access size
    localparam logic [1:0] LD_B = 2'b00;
    localparam logic [1:0] LD_H = 2'b01;
    localparam logic [1:0] LD_W = 2'b10;
    localparam logic [1:0] LD_D = 2'b11;
    // load_op bit selecting zero extension
    localparam int LD_UNSIGNED = 2;

    // exception codes
    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_PIL = 6'h01;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    // Number of single-bit MEM-to-WB fields plus the 3-bit load_op:
    // gr_we, res_from_mem, res_from_csr, csr_we, ex, badv_we, ertn, load_op[2:0]
    localparam int MS2WS_CTRL_W = 10;
    // Datapath-wide fields: pc, alu_result, mem_rdata, csr_wdata, csr_wmask, badv
    localparam int MS2WS_DATA_FIELDS = 6;

    // Total width of the MEM-to-WB payload bus for a given configuration.
    function automatic int ms2ws_bus_w(input int data_w, input int reg_aw,
                                       input int csr_aw, input int ecode_w,
                                       input int lane_w);
        return MS2WS_DATA_FIELDS * data_w + reg_aw + csr_aw + ecode_w + lane_w
               + MS2WS_CTRL_W;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - byte/half/word/double lane select with sign or zero extension
module load_extend
    import core_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [2:0]        load_op,
    output logic [DATA_W-1:0] result
);

    logic [LANE_W-1:0] h_idx;
    logic [LANE_W-1:0] w_idx;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;
    logic              is_unsigned;

    // Half and word indices drop the low address bits; on a 32-bit datapath
    // the word index is always zero.
    assign h_idx       = addr_lo >> 1;
    assign w_idx       = addr_lo >> 2;
    assign lane_b      = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h      = rdata[{h_idx, 4'b0000} +: 16];
    assign lane_w      = rdata[{w_idx, 5'b00000} +: 32];
    assign is_unsigned = load_op[LD_UNSIGNED];

    // Extend the selected lane to the datapath width; a double load passes through.
    always_comb begin
        result = rdata;
        case (load_op[1:0])
            LD_B: result = is_unsigned ? DATA_W'(lane_b) : DATA_W'($signed(lane_b));
            LD_H: result = is_unsigned ? DATA_W'(lane_h) : DATA_W'($signed(lane_h));
            LD_W: result = is_unsigned ? DATA_W'(lane_w) : DATA_W'($signed(lane_w));
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - write-back/commit stage with precise exception commit
module wb_commit_stage
    import core_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int CSR_AW  = 14,
    parameter int ECODE_W = 6,
    parameter int CNT_W   = 64,
    localparam int LANE_W = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ms_valid,
    output logic               ws_allowin,
    input  logic [DATA_W-1:0]  ms_pc,
    input  logic               ms_gr_we,
    input  logic [REG_AW-1:0]  ms_dest,
    input  logic [DATA_W-1:0]  ms_alu_result,
    input  logic [DATA_W-1:0]  ms_mem_rdata,
    input  logic [LANE_W-1:0]  ms_addr_lo,
    input  logic               ms_res_from_mem,
    input  logic [2:0]         ms_load_op,
    input  logic               ms_res_from_csr,
    input  logic               ms_csr_we,
    input  logic [CSR_AW-1:0]  ms_csr_num,
    input  logic [DATA_W-1:0]  ms_csr_wdata,
    input  logic [DATA_W-1:0]  ms_csr_wmask,
    input  logic               ms_ex,
    input  logic [ECODE_W-1:0] ms_ecode,
    input  logic               ms_badv_we,
    input  logic [DATA_W-1:0]  ms_badv,
    input  logic               ms_ertn,
    input  logic [DATA_W-1:0]  csr_rvalue,
    output logic               rf_we,
    output logic [REG_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [REG_AW-1:0]  fwd_dest,
    output logic               fwd_from_mem,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               csr_we,
    output logic [CSR_AW-1:0]  csr_num,
    output logic [DATA_W-1:0]  csr_wdata,
    output logic [DATA_W-1:0]  csr_wmask,
    output logic               wb_ex,
    output logic [ECODE_W-1:0] wb_ecode,
    output logic [DATA_W-1:0]  wb_era,
    output logic               wb_badv_we,
    output logic [DATA_W-1:0]  wb_badv,
    output logic               wb_ertn,
    output logic               wb_flush,
    output logic [CNT_W-1:0]   instret,
    output logic [DATA_W-1:0]  debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [REG_AW-1:0]  debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
);

    localparam int BUS_W = ms2ws_bus_w(DATA_W, REG_AW, CSR_AW, ECODE_W, LANE_W);

    logic              ws_valid;
    logic              ws_ready_go;
    logic [BUS_W-1:0]  ms_bus;
    logic [BUS_W-1:0]  ws_bus;

    logic [DATA_W-1:0]  ws_pc;
    logic               ws_gr_we;
    logic [REG_AW-1:0]  ws_dest;
    logic [DATA_W-1:0]  ws_alu_result;
    logic [DATA_W-1:0]  ws_mem_rdata;
    logic [LANE_W-1:0]  ws_addr_lo;
    logic               ws_res_from_mem;
    logic [2:0]         ws_load_op;
    logic               ws_res_from_csr;
    logic               ws_csr_we;
    logic [CSR_AW-1:0]  ws_csr_num;
    logic [DATA_W-1:0]  ws_csr_wdata;
    logic [DATA_W-1:0]  ws_csr_wmask;
    logic               ws_ex;
    logic [ECODE_W-1:0] ws_ecode;
    logic               ws_badv_we;
    logic [DATA_W-1:0]  ws_badv;
    logic               ws_ertn;
    logic [DATA_W-1:0]  load_result;
    logic [DATA_W-1:0]  final_result;

    // Pack and unpack use the same field order so the bus stays consistent.
    assign ms_bus = {ms_pc, ms_gr_we, ms_dest, ms_alu_result, ms_mem_rdata, ms_addr_lo,
                     ms_res_from_mem, ms_load_op, ms_res_from_csr, ms_csr_we, ms_csr_num,
                     ms_csr_wdata, ms_csr_wmask, ms_ex, ms_ecode, ms_badv_we, ms_badv,
                     ms_ertn};
    assign {ws_pc, ws_gr_we, ws_dest, ws_alu_result, ws_mem_rdata, ws_addr_lo,
            ws_res_from_mem, ws_load_op, ws_res_from_csr, ws_csr_we, ws_csr_num,
            ws_csr_wdata, ws_csr_wmask, ws_ex, ws_ecode, ws_badv_we, ws_badv,
            ws_ertn} = ws_bus;

    assign ws_ready_go = 1'b1;
    assign ws_allowin  = !ws_valid || ws_ready_go;

    // Stage valid: a flush kills whatever MEM offers on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_valid <= 1'b0;
        end else if (wb_flush) begin
            ws_valid <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid <= ms_valid;
        end
    end

    // Payload register: captures MEM fields on an accepted handshake.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ws_bus <= '0;
        end else if (ms_valid && ws_allowin && !wb_flush) begin
            ws_bus <= ms_bus;
        end
    end

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .rdata   (ws_mem_rdata),
        .addr_lo (ws_addr_lo),
        .load_op (ws_load_op),
        .result  (load_result)
    );

    assign final_result = ws_res_from_mem ? load_result :
                          ws_res_from_csr ? csr_rvalue  : ws_alu_result;

    // An excepting instruction suppresses every architectural side effect.
    assign rf_we      = ws_valid & ws_gr_we & !ws_ex;
    assign rf_waddr   = ws_dest;
    assign rf_wdata   = final_result;
    assign csr_we     = ws_valid & ws_csr_we & !ws_ex;
    assign csr_num    = ws_csr_num;
    assign csr_wdata  = ws_csr_wdata;
    assign csr_wmask  = ws_csr_wmask;
    assign wb_ex      = ws_valid & ws_ex;
    assign wb_ecode   = ws_ecode;
    assign wb_era     = ws_pc;
    assign wb_ertn    = ws_valid & ws_ertn & !ws_ex;
    assign wb_badv_we = wb_ex & ws_badv_we;
    assign wb_badv    = ws_badv;
    assign wb_flush   = wb_ex | wb_ertn;

    assign fwd_dest     = rf_we ? ws_dest : '0;
    assign fwd_from_mem = ws_valid & ws_res_from_mem;
    assign fwd_data     = final_result;

    assign debug_wb_pc       = ws_pc;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = ws_dest;
    assign debug_wb_rf_wdata = final_result;

    // Retired-instruction counter; ertn retires, exceptions do not. Wraps naturally.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            instret <= '0;
        end else if (ws_valid && !ws_ex) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule
